mem_bus_datapath: RTL

MEM_BUS_DATAPATH -- requirements
Module: mem_bus_datapath

---
 rtl/mem_bus_datapath.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_datapath.sv
// Single-bus CPU datapath: register file, PC, Y/Z/MAR/MDR, bus arbitration
// with conflict detection, and a memory handshake FSM with a wait-cycle timeout.
module mem_bus_datapath #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned NREG    = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [NREG-1:0]       reg_in,
  input  logic [NREG-1:0]       reg_out,
  input  logic                  BAout,
  input  logic                  PCin,
  input  logic                  IncPC,
  input  logic                  PCout,
  input  logic                  MARin,
  input  logic                  MDRin,
  input  logic                  MDRout,
  input  logic                  Yin,
  input  logic                  ZIn,
  input  logic                  Zhighout,
  input  logic                  Zlowout,
  input  logic [2*DATA_W-1:0]   alu_result,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic [DATA_W-1:0]     bus_out,
  output logic [DATA_W-1:0]     y_value,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  bus_conflict,
  output logic                  mem_timeout
);

  // Bus sources: R0 and BAout share one slot, plus R1..Rn-1, PC, MDR, Zhigh, Zlow.
  localparam int unsigned NSRC   = NREG + 4;
  localparam int unsigned SCNT_W = $clog2(NSRC + 1);
  localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } state_t;

  logic [DATA_W-1:0]   r_regs [NREG];
  logic [DATA_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_y;
  logic [2*DATA_W-1:0] r_z;
  logic [ADDR_W-1:0]   r_mar;
  logic [DATA_W-1:0]   r_mdr;
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_req;
  logic                r_we;
  logic                r_busy;
  logic                r_conf;
  logic                r_tout;

  logic [NSRC-1:0]     w_src;
  logic [SCNT_W-1:0]   w_src_cnt;
  logic [DATA_W-1:0]   w_bus_or;
  logic                w_multi;
  logic [DATA_W-1:0]   w_bus;

  assign w_src = {Zlowout, Zhighout, MDRout, PCout, reg_out[NREG-1:1], reg_out[0] | BAout};

  // Count active sources and merge their values; more than one forces the bus to zero.
  always_comb begin
    w_src_cnt = '0;
    w_bus_or  = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      w_src_cnt = w_src_cnt + SCNT_W'(w_src[i]);
    end
    if (reg_out[0] && !BAout) w_bus_or = w_bus_or | r_regs[0];
    for (int i = 1; i < int'(NREG); i++) begin
      if (reg_out[i]) w_bus_or = w_bus_or | r_regs[i];
    end
    if (PCout)    w_bus_or = w_bus_or | r_pc;
    if (MDRout)   w_bus_or = w_bus_or | r_mdr;
    if (Zhighout) w_bus_or = w_bus_or | r_z[2*DATA_W-1:DATA_W];
    if (Zlowout)  w_bus_or = w_bus_or | r_z[DATA_W-1:0];
    w_multi = (w_src_cnt > SCNT_W'(1));
    w_bus   = w_multi ? '0 : w_bus_or;
  end

  assign bus_out      = w_bus;
  assign y_value      = r_y;
  assign mem_addr     = r_mar;
  assign mem_wdata    = r_mdr;
  assign mem_req      = r_req;
  assign mem_we       = r_we;
  assign busy         = r_busy;
  assign bus_conflict = r_conf;
  assign mem_timeout  = r_tout;

  // Register file, PC, Y, Z and MAR loads from the bus; MAR frozen during an access.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
      r_pc  <= '0;
      r_y   <= '0;
      r_z   <= '0;
      r_mar <= '0;
    end else begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (reg_in[i]) r_regs[i] <= w_bus;
      end
      if (PCin)       r_pc <= w_bus;
      else if (IncPC) r_pc <= r_pc + DATA_W'(1);
      if (Yin) r_y <= w_bus;
      if (ZIn) r_z <= alu_result;
      if (MARin && !r_busy) r_mar <= w_bus[ADDR_W-1:0];
    end
  end

  // Memory handshake FSM; also owns MDR and the sticky conflict/timeout flags.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_mdr   <= '0;
      r_conf  <= 1'b0;
      r_tout  <= 1'b0;
    end else begin
      if (w_multi) r_conf <= 1'b1;
      if (MDRin && !r_busy) r_mdr <= w_bus;
      case (r_state)
        ST_IDLE: begin
          if (Read && Write) begin
            r_conf <= 1'b1;
          end else if (Read) begin
            r_state <= ST_RD_WAIT;
            r_cnt   <= '0;
            r_req   <= 1'b1;
            r_we    <= 1'b0;
            r_busy  <= 1'b1;
          end else if (Write) begin
            r_state <= ST_WR_WAIT;
            r_cnt   <= '0;
            r_req   <= 1'b1;
            r_we    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_RD_WAIT, ST_WR_WAIT: begin
          if (mem_ack) begin
            if (r_state == ST_RD_WAIT) r_mdr <= mem_rdata;
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_tout  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
